// File: rtl/regxfer_pkg.sv
// Shared types and constants for the register-file block-transfer sequencer.
package regxfer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST_SEND = 3'd1,
        LD_REQ  = 3'd2,
        LD_WAIT = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic {
        MODE_STORE = 1'b0,
        MODE_LOAD  = 1'b1
    } mode_t;

    localparam int XZR_IDX        = 31;
    localparam int STRIDE_DEFAULT = 8;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of a register mask plus an any-set flag.
module lowest_set_idx #(
    parameter int N_REGS = 32,
    parameter int IDX_W  = 5
) (
    input  logic [N_REGS-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downward so the lowest set bit is the last (winning) assignment.
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/regfile_xfer_seq.sv
// LDM/STM-style sequencer moving a masked set of registers between the regfile and memory.
// Optional build macro REGXFER_XZR_SKIP_EN: drop X31 from the mask when a sequence starts.
module regfile_xfer_seq
    import regxfer_pkg::*;
#(
    parameter int N_REGS = 32,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64,
    parameter int STRIDE = STRIDE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [N_REGS-1:0] mask,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [5:0]        xfer_count,
    output logic [4:0]        ra,
    input  logic [DATA_W-1:0] rd,
    output logic              we3,
    output logic [4:0]        wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [ADDR_W-1:0] st_addr,
    output logic [DATA_W-1:0] st_data,
    output logic              ld_req_valid,
    input  logic              ld_req_ready,
    output logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_rsp_valid,
    input  logic [DATA_W-1:0] ld_rsp_data
);

    state_t              state_q, state_d;
    logic [N_REGS-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [5:0]          cnt_q, cnt_d;

    logic [N_REGS-1:0]   start_mask;
    logic [N_REGS-1:0]   scan_mask;
    logic [N_REGS-1:0]   idx_onehot;
    logic [N_REGS-1:0]   mask_clr;
    logic [4:0]          idx;
    logic                any_set;
    logic                more;

    always_comb begin
        start_mask = mask;
`ifdef REGXFER_XZR_SKIP_EN
        start_mask[XZR_IDX] = 1'b0;
`endif
    end

    // In IDLE the encoder looks at the incoming mask so the first index is known at start.
    assign scan_mask = (state_q == IDLE) ? start_mask : mask_q;

    lowest_set_idx #(.N_REGS(N_REGS), .IDX_W(5)) u_lsi (
        .mask (scan_mask),
        .idx  (idx),
        .any  (any_set)
    );

    always_comb begin
        idx_onehot      = '0;
        idx_onehot[idx] = 1'b1;
    end

    assign mask_clr   = mask_q & ~idx_onehot;
    assign more       = |mask_clr;
    assign xfer_count = cnt_q;
    assign st_addr    = addr_q;
    assign ld_addr    = addr_q;

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        busy         = 1'b0;
        done         = 1'b0;
        ra           = '0;
        we3          = 1'b0;
        wa3          = '0;
        wd3          = '0;
        st_valid     = 1'b0;
        st_data      = '0;
        ld_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = start_mask;
                    addr_d = base_addr;
                    cnt_d  = '0;
                    if (!any_set) begin
                        state_d = DONE;
                    end else if (mode_t'(mode) == MODE_LOAD) begin
                        state_d = LD_REQ;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                busy     = 1'b1;
                ra       = idx;
                st_valid = 1'b1;
                st_data  = rd;
                if (st_ready) begin
                    mask_d  = mask_clr;
                    addr_d  = addr_q + ADDR_W'(STRIDE);
                    cnt_d   = cnt_q + 6'd1;
                    state_d = more ? ST_SEND : DONE;
                end
            end
            LD_REQ: begin
                busy         = 1'b1;
                ld_req_valid = 1'b1;
                if (ld_req_ready) begin
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                busy = 1'b1;
                if (ld_rsp_valid) begin
                    we3     = 1'b1;
                    wa3     = idx;
                    wd3     = ld_rsp_data;
                    mask_d  = mask_clr;
                    addr_d  = addr_q + ADDR_W'(STRIDE);
                    cnt_d   = cnt_q + 6'd1;
                    state_d = more ? LD_REQ : DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_xfer_seq.sv
// Scoreboard bench for regfile_xfer_seq: regfile preloaded Xi=i, random memory-side handshakes.
module tb_regfile_xfer_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] mask = '0;
    logic [63:0] base_addr = '0;
    logic        busy, done, we3, st_valid, ld_req_valid;
    logic [5:0]  xfer_count;
    logic [4:0]  ra, wa3;
    logic [63:0] rd, wd3, st_addr, st_data, ld_addr;
    logic        st_ready = 1'b0;
    logic        ld_req_ready = 1'b0;
    logic        ld_rsp_valid = 1'b0;
    logic [63:0] ld_rsp_data = '0;

    always #5 clk = ~clk;

    regfile_xfer_seq dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .mask(mask),
        .base_addr(base_addr), .busy(busy), .done(done), .xfer_count(xfer_count),
        .ra(ra), .rd(rd), .we3(we3), .wa3(wa3), .wd3(wd3),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_addr(ld_addr),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data)
    );

    int total = 0;
    int bad = 0;
    int st_ctl = 0;     // 0: ready high, 1: random, 2: driven by the main sequence
    int ldr_ctl = 0;    // 0: ready high, 1: random
    int lat_sel = -1;   // load response latency, -1 = random 0..3
    int we3_cycles = 0;
    int done_cnt = 0;

    logic [127:0] exp_st[$];
    logic [63:0]  exp_ld[$];
    logic [68:0]  exp_wr[$];
    logic [5:0]   exp_done[$];
    logic [63:0]  rsp_q[$];
    logic [63:0]  fixed_q[$];

    // Register file: X31 reads zero and ignores writes.
    logic [63:0] rf [32];
    assign rd = (ra == 5'd31) ? 64'd0 : rf[ra];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'(i);
        forever begin
            @(posedge clk);
            if (we3 && wa3 != 5'd31) rf[wa3] = wd3;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (st_ctl == 0) st_ready = 1'b1;
            else if (st_ctl == 1) st_ready = 1'($urandom_range(0, 1));
            if (ldr_ctl == 0) ld_req_ready = 1'b1;
            else ld_req_ready = 1'($urandom_range(0, 1));
        end
    end

    // Memory load responder: one outstanding request, data taken from rsp_q.
    initial begin
        forever begin
            @(negedge clk);
            if (ld_req_valid && ld_req_ready && !reset) begin
                int lat;
                lat = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1;
                ld_rsp_valid = 1'b1;
                ld_rsp_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 64'd0;
                @(posedge clk);
                #1;
                ld_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT presents a beat, write or done.
    logic [127:0] m_st;
    logic [68:0]  m_wr;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (st_valid && st_ready) begin
                    if (exp_st.size() == 0) chk("st_beat_unexpected", 64'd1, 64'd0);
                    else begin
                        m_st = exp_st.pop_front();
                        chk("st_addr", st_addr, m_st[127:64]);
                        chk("st_data", st_data, m_st[63:0]);
                    end
                end
                if (ld_req_valid && ld_req_ready) begin
                    if (exp_ld.size() == 0) chk("ld_req_unexpected", 64'd1, 64'd0);
                    else chk("ld_addr", ld_addr, exp_ld.pop_front());
                end
                if (we3) begin
                    we3_cycles++;
                    if (exp_wr.size() == 0) chk("we3_unexpected", 64'd1, 64'd0);
                    else begin
                        m_wr = exp_wr.pop_front();
                        chk("wa3", 64'(wa3), 64'(m_wr[68:64]));
                        chk("wd3", wd3, m_wr[63:0]);
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("busy_during_done", 64'(busy), 64'd0);
                    if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                    else chk("xfer_count", 64'(xfer_count), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    // Reference model: walk the mask in ascending order, one beat per set bit.
    task automatic issue(input logic m, input logic [31:0] msk, input logic [63:0] base);
        logic [31:0] eff;
        logic [63:0] a;
        logic [63:0] d;
        int n;
        eff = msk;
`ifdef REGXFER_XZR_SKIP_EN
        eff[31] = 1'b0;
`endif
        a = base;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (eff[i]) begin
                if (!m) begin
                    exp_st.push_back({a, (i == 31) ? 64'd0 : rf[i]});
                end else begin
                    if (fixed_q.size() > 0) d = fixed_q.pop_front();
                    else d = {$urandom, $urandom};
                    rsp_q.push_back(d);
                    exp_ld.push_back(a);
                    exp_wr.push_back({5'(i), d});
                end
                a = a + 64'd8;
                n++;
            end
        end
        exp_done.push_back(6'(n));
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; mask = msk; base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0; mode = 1'($urandom); mask = $urandom; base_addr = {$urandom, $urandom};
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    int n;
    int d0, w0;
    logic [31:0] rmask;
    logic [63:0] rbase;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_we3", 64'(we3), 0);
        chk("rst_st_valid", 64'(st_valid), 0);
        chk("rst_ld_req_valid", 64'(ld_req_valid), 0);
        chk("rst_ra", 64'(ra), 0);
        chk("rst_wa3", 64'(wa3), 0);
        chk("rst_xfer_count", 64'(xfer_count), 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_st_addr", st_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two-register store, ready held high: k beats + 1 done cycle
        issue(1'b0, 32'h0000_000A, 64'h100);
        wait_done(n);
        chk("store2_cycles", 64'(n), 64'd3);

        // Backpressure: outputs held while st_ready is low
        st_ctl = 2;
        st_ready = 1'b0;
        issue(1'b0, 32'h1, 64'h200);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_st_valid", 64'(st_valid), 64'd1);
            chk("stall_st_addr", st_addr, 64'h200);
            chk("stall_st_data", st_data, 64'd0);
        end
        @(posedge clk);
        #1;
        st_ready = 1'b1;
        wait_done(n);
        chk("stall_done_cycles", 64'(n), 64'd2);
        st_ctl = 0;

        // Load with fixed 2-cycle response latency
        fixed_q.push_back(64'hAA);
        fixed_q.push_back(64'hBB);
        lat_sel = 2;
        we3_cycles = 0;
        issue(1'b1, 32'h0000_0030, 64'h300);
        wait_done(n);
        chk("load_x4", rf[4], 64'hAA);
        chk("load_x5", rf[5], 64'hBB);
        chk("load_we3_cycles", 64'(we3_cycles), 64'd2);
        lat_sel = -1;

        // Empty mask
        issue(1'b0, 32'h0, 64'h400);
        wait_done(n);
        chk("empty_done_cycles", 64'(n), 64'd1);

        // start pulsed while busy is ignored
        st_ctl = 1;
        issue(1'b0, 32'h0000_00F0, 64'h500);
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b1; mask = 32'hFF; base_addr = 64'h5000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n);
        st_ctl = 0;

        // start pulsed during the DONE cycle is ignored
        d0 = done_cnt;
        issue(1'b0, 32'h3, 64'h600);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b0; mask = 32'hFF; base_addr = 64'h6000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("done_start_ignored_busy", 64'(busy), 64'd0);
        chk("done_start_ignored_cnt", 64'(done_cnt - d0), 64'd1);

        // X31 store
        issue(1'b0, 32'h8000_0000, 64'h700);
        wait_done(n);
`ifdef REGXFER_XZR_SKIP_EN
        chk("xzr_cycles", 64'(n), 64'd1);
`else
        chk("xzr_cycles", 64'(n), 64'd2);
`endif

        // Reset in the middle of a load after two beats
        lat_sel = 1;
        we3_cycles = 0;
        issue(1'b1, 32'h0000_00FF, 64'h800);
        n = 0;
        while (we3_cycles < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_two_writes", 64'(we3_cycles), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_st.delete(); exp_ld.delete(); exp_wr.delete(); exp_done.delete(); rsp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        d0 = done_cnt;
        w0 = we3_cycles;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_we3", 64'(we3), 64'd0);
        chk("abort_xfer_count", 64'(xfer_count), 64'd0);
        repeat (8) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_no_we3", 64'(we3_cycles - w0), 64'd0);
        chk("abort_x2_untouched", rf[2], 64'd2);
        lat_sel = -1;
        issue(1'b1, 32'h3, 64'h900);
        wait_done(n);

        // Randomized sequences
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 3))
                0: rmask = $urandom & $urandom & $urandom;
                1: rmask = $urandom;
                2: rmask = 32'hFFFF_FFFF;
                default: rmask = 32'h1 << $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 3) == 0) rbase = 64'hFFFF_FFFF_FFFF_FFE8;
            else rbase = {$urandom, $urandom} & ~64'h7;
            st_ctl = int'($urandom_range(0, 1));
            ldr_ctl = int'($urandom_range(0, 1));
            issue(1'($urandom_range(0, 1)), rmask, rbase);
            wait_done(n);
        end
        st_ctl = 0;
        ldr_ctl = 0;
        repeat (3) @(negedge clk);

        chk("left_st", 64'(exp_st.size()), 64'd0);
        chk("left_ld", 64'(exp_ld.size()), 64'd0);
        chk("left_wr", 64'(exp_wr.size()), 64'd0);
        chk("left_done", 64'(exp_done.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
